// File: rtl/regfile_read_arbiter.sv
// Two-port round-robin read arbiter in front of a shared 32:1 register-file read mux.
// Define REGFILE_READ_ARBITER_SCAN_EN to add a lowest-priority scan engine that reads all 32 entries.
module regfile_read_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic [4:0]   addr_a,
  output logic         gnt_a,
  output logic         rvalid_a,
  output logic [N-1:0] rdata_a,
  input  logic         req_b,
  input  logic [4:0]   addr_b,
  output logic         gnt_b,
  output logic         rvalid_b,
  output logic [N-1:0] rdata_b,
  output logic [4:0]   mux_s,
  output logic         mux_en,
  input  logic [N-1:0] mux_o
`ifdef REGFILE_READ_ARBITER_SCAN_EN
  ,
  input  logic         scan_start,
  output logic         scan_busy,
  output logic         scan_valid,
  output logic [4:0]   scan_idx,
  output logic [N-1:0] scan_data,
  output logic         scan_done
`endif
);

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  logic last_gnt_q;

`ifdef REGFILE_READ_ARBITER_SCAN_EN
  typedef enum logic [0:0] {SCAN_IDLE, SCAN_RUN} scan_state_e;
  scan_state_e scan_state_q;
  logic        gnt_s;
`endif

  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    mux_s  = 5'd0;
`ifdef REGFILE_READ_ARBITER_SCAN_EN
    gnt_s  = 1'b0;
`endif
    if (rst) begin
      if (req_a && (!req_b || last_gnt_q == PortB)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
`ifdef REGFILE_READ_ARBITER_SCAN_EN
      // One scan read in flight at a time so scan_idx names the entry being returned.
      else if (scan_state_q == SCAN_RUN && !scan_valid) begin
        gnt_s = 1'b1;
      end
`endif
    end
    if (gnt_a) begin
      mux_s = addr_a;
    end else if (gnt_b) begin
      mux_s = addr_b;
    end
`ifdef REGFILE_READ_ARBITER_SCAN_EN
    else if (gnt_s) begin
      mux_s = scan_idx;
    end
    mux_en = gnt_a | gnt_b | gnt_s;
`else
    mux_en = gnt_a | gnt_b;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      last_gnt_q <= PortB;
    end else begin
      rvalid_a <= gnt_a;
      rvalid_b <= gnt_b;
      if (gnt_a) rdata_a <= mux_o;
      if (gnt_b) rdata_b <= mux_o;
      if (gnt_a || gnt_b) last_gnt_q <= gnt_b ? PortB : PortA;
    end
  end

`ifdef REGFILE_READ_ARBITER_SCAN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_state_q <= SCAN_IDLE;
      scan_busy    <= 1'b0;
      scan_valid   <= 1'b0;
      scan_idx     <= 5'd0;
      scan_data    <= '0;
      scan_done    <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
      unique case (scan_state_q)
        SCAN_IDLE: begin
          if (scan_start) begin
            scan_state_q <= SCAN_RUN;
            scan_busy    <= 1'b1;
            scan_idx     <= 5'd0;
          end
        end
        SCAN_RUN: begin
          if (gnt_s) begin
            scan_valid <= 1'b1;
            scan_data  <= mux_o;
            scan_done  <= (scan_idx == 5'd31);
          end
          // Advance only after the pulse so scan_idx stays aligned with scan_data.
          if (scan_valid) begin
            scan_idx <= scan_idx + 5'd1;
            if (scan_done) begin
              scan_state_q <= SCAN_IDLE;
              scan_busy    <= 1'b0;
            end
          end
        end
        default: scan_state_q <= SCAN_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed vector table, idle and random runs
// against a behavioural model, plus a scan sequence when REGFILE_READ_ARBITER_SCAN_EN is set.
module tb_regfile_read_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b;
  logic [4:0]   addr_a, addr_b;
  logic         gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [N-1:0] rdata_a, rdata_b;
  logic [4:0]   mux_s;
  logic         mux_en;
  logic [N-1:0] mux_o;
`ifdef REGFILE_READ_ARBITER_SCAN_EN
  logic         scan_start, scan_busy, scan_valid, scan_done;
  logic [4:0]   scan_idx;
  logic [N-1:0] scan_data;
`endif

  logic [N-1:0] mem [32];
  assign mux_o = mem[mux_s];

  always #5 clk = ~clk;

  regfile_read_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mux_s(mux_s), .mux_en(mux_en), .mux_o(mux_o)
`ifdef REGFILE_READ_ARBITER_SCAN_EN
    ,
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_idx(scan_idx), .scan_data(scan_data), .scan_done(scan_done)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: last winner (1 = B), expected grants this cycle, registered read results.
  logic         m_last_b;
  logic         m_ga, m_gb;
  logic         m_rv_a, m_rv_b;
  logic [N-1:0] m_rd_a, m_rd_b;

  // Call at the negedge: checks the combinational grant/mux outputs.
  task automatic comb_check();
    logic [4:0] es;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (rst === 1'b1) begin
      if (req_a && req_b) begin
        m_ga = m_last_b;
        m_gb = !m_last_b;
      end else begin
        m_ga = req_a;
        m_gb = req_b;
      end
    end
    es = m_ga ? addr_a : (m_gb ? addr_b : 5'd0);
    chk("gnt_a", gnt_a, m_ga);
    chk("gnt_b", gnt_b, m_gb);
    chk("gnt_onehot", gnt_a & gnt_b, 0);
    chk("mux_en", mux_en, m_ga | m_gb);
    chk("mux_s", mux_s, es);
  endtask

  // Advances through the posedge, updates the model, checks the registered outputs.
  task automatic seq_check();
    @(posedge clk);
    if (rst !== 1'b1) begin
      m_last_b = 1'b1;
      m_rv_a = 1'b0;
      m_rv_b = 1'b0;
      m_rd_a = '0;
      m_rd_b = '0;
    end else begin
      m_rv_a = m_ga;
      m_rv_b = m_gb;
      if (m_ga) m_rd_a = mem[addr_a];
      if (m_gb) m_rd_b = mem[addr_b];
      if (m_ga || m_gb) m_last_b = m_gb;
    end
    #1;
    chk("rvalid_a", rvalid_a, m_rv_a);
    chk("rvalid_b", rvalid_b, m_rv_b);
    chk("rdata_a", rdata_a, m_rd_a);
    chk("rdata_b", rdata_b, m_rd_b);
  endtask

  task automatic cycle();
    @(negedge clk);
    comb_check();
    seq_check();
  endtask

  typedef struct {
    logic       rst;
    logic       ra;
    logic [4:0] aa;
    logic       rb;
    logic [4:0] ab;
    logic       ega;
    logic       egb;
    logic [4:0] ems;
    logic       emen;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1};  // tie after reset -> A
    tbl[1]  = '{1'b1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1};  // single A, DEADBEEF
    tbl[5]  = '{1'b0, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0};  // reset mid-flight
    tbl[6]  = '{1'b1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1};  // first tie -> A
    tbl[7]  = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 5'd1, 1'b1};  // B back-to-back
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b1, 5'd2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1};  // same address, last=B
    tbl[11] = '{1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};

    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;

    rst = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    addr_a = 5'd0;
    addr_b = 5'd0;
`ifdef REGFILE_READ_ARBITER_SCAN_EN
    scan_start = 1'b0;
`endif
    m_last_b = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      req_a = tbl[i].ra;
      addr_a = tbl[i].aa;
      req_b = tbl[i].rb;
      addr_b = tbl[i].ab;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt_a", i), gnt_a, tbl[i].ega);
      chk($sformatf("vec%0d_gnt_b", i), gnt_b, tbl[i].egb);
      chk($sformatf("vec%0d_mux_s", i), mux_s, tbl[i].ems);
      chk($sformatf("vec%0d_mux_en", i), mux_en, tbl[i].emen);
      comb_check();
      seq_check();
      if (i <= 4) chk($sformatf("vec%0d_one_rvalid", i), int'(rvalid_a) + int'(rvalid_b), 1);
      if (i == 4) chk("single_rdata_a", rdata_a, 32'hDEADBEEF);
      if (i == 5) chk("reset_rdata_a", rdata_a, 0);
    end

    rst = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      req_a = 1'($urandom);
      req_b = 1'($urandom);
      addr_a = 5'($urandom);
      addr_b = 5'($urandom);
      cycle();
    end

`ifdef REGFILE_READ_ARBITER_SCAN_EN
    begin
      int   exp_idx;
      bit   done_seen;
      logic pend;
      logic [4:0] pa;
      rst = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      cycle();
      rst = 1'b1;
      scan_start = 1'b1;
      @(posedge clk);
      #1;
      scan_start = 1'b0;
      chk("scan_busy_start", scan_busy, 1);
      exp_idx = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 300 && !done_seen; c++) begin
        req_a = (c >= 4 && c < 7);
        addr_a = 5'(c);
        scan_start = (c == 20);
        @(negedge clk);
        if (req_a) begin
          chk("scan_gnt_a", gnt_a, 1);
          chk("scan_mux_s_a", mux_s, addr_a);
        end
        pend = gnt_a;
        pa = addr_a;
        @(posedge clk);
        #1;
        if (pend) begin
          chk("scan_rvalid_a", rvalid_a, 1);
          chk("scan_rdata_a", rdata_a, mem[pa]);
        end
        if (scan_valid) begin
          chk("scan_idx", scan_idx, 5'(exp_idx));
          chk("scan_data", scan_data, mem[exp_idx[4:0]]);
          chk("scan_done", scan_done, exp_idx == 31);
          if (scan_done) done_seen = 1'b1;
          exp_idx++;
        end else if (scan_done) begin
          chk("scan_done_alone", scan_done, 0);
        end
      end
      scan_start = 1'b0;
      req_a = 1'b0;
      chk("scan_count", exp_idx, 32);
      @(posedge clk);
      #1;
      chk("scan_busy_end", scan_busy, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
